// File: rtl/draw_scheduler.sv
// Cursor/bitmap owner that serialises cursor redraws onto the vga_display draw_enable/drawing handshake.
// Latency: move pulse at n -> target at n+1 -> draw_enable during n+2; step_col read is combinational.
// Backpressure: one transaction in flight; moves arriving meanwhile coalesce into one follow-up draw.
// Optional build macro DRAW_SCHED_WRAP_EN: cursor wraps at the grid edges instead of saturating.
module draw_scheduler #(
   parameter int GRID_N = 12,
   parameter int X0     = 214,
   parameter int Y0     = 32,
   parameter int PITCH  = 33
) (
   input  logic              CLOCK_50,
   input  logic              nReset,
   input  logic              btn_up,
   input  logic              btn_down,
   input  logic              btn_left,
   input  logic              btn_right,
   input  logic              btn_toggle,
   input  logic              drawing,
   output logic              draw_enable,
   output logic [9:0]        X,
   output logic [8:0]        Y,
   output logic [9:0]        OLD_X,
   output logic [8:0]        OLD_Y,
   output logic              state,
   output logic [3:0]        cursor_col,
   output logic [3:0]        cursor_row,
   output logic              busy,
   input  logic [3:0]        step_col_sel,
   output logic [GRID_N-1:0] step_col
);

   typedef enum logic [2:0] {INIT, IDLE, ISSUE, W_START, W_CUR, W_GAP, W_BOX} fsm_t;

   fsm_t                          fsm_q, fsm_d;
   logic                          init_hi_q, init_hi_d;
   logic [3:0]                    tgt_col_q, tgt_col_d, tgt_row_q, tgt_row_d;
   logic [3:0]                    disp_col_q, disp_col_d, disp_row_q, disp_row_d;
   logic [GRID_N-1:0][GRID_N-1:0] bitmap_q, bitmap_d;   // [col][row]
   logic [9:0]                    x_q, x_d, old_x_q, old_x_d;
   logic [8:0]                    y_q, y_d, old_y_q, old_y_d;
   logic                          cell_q, cell_d;

   // One axis step; opposing pulses cancel, edges wrap or saturate by build option.
   function automatic logic [3:0] step_pos(input logic [3:0] v, input logic dec, input logic inc);
      logic [3:0] r;
      r = v;
      if (dec && !inc) begin
`ifdef DRAW_SCHED_WRAP_EN
         r = (v == 4'd0) ? 4'(GRID_N - 1) : v - 4'd1;
`else
         r = (v == 4'd0) ? v : v - 4'd1;
`endif
      end else if (inc && !dec) begin
`ifdef DRAW_SCHED_WRAP_EN
         r = (v == 4'(GRID_N - 1)) ? 4'd0 : v + 4'd1;
`else
         r = (v == 4'(GRID_N - 1)) ? v : v + 4'd1;
`endif
      end
      return r;
   endfunction

   function automatic logic [9:0] pix_x(input logic [3:0] col);
      return 10'(X0) + 10'(PITCH) * {6'd0, col};
   endfunction

   function automatic logic [8:0] pix_y(input logic [3:0] row);
      return 9'(Y0) + 9'(PITCH) * {5'd0, row};
   endfunction

   // Next-state: cursor/bitmap updates from buttons, transaction sequencing, output latching.
   always_comb begin
      fsm_d      = fsm_q;
      init_hi_d  = init_hi_q;
      tgt_col_d  = step_pos(tgt_col_q, btn_left, btn_right);
      tgt_row_d  = step_pos(tgt_row_q, btn_up, btn_down);
      disp_col_d = disp_col_q;
      disp_row_d = disp_row_q;
      bitmap_d   = bitmap_q;
      x_d        = x_q;
      y_d        = y_q;
      old_x_d    = old_x_q;
      old_y_d    = old_y_q;
      cell_d     = cell_q;
      // Toggle hits the pre-move cell; the cursor hides it so no redraw is needed.
      if (btn_toggle)
         bitmap_d[tgt_col_q][tgt_row_q] = ~bitmap_q[tgt_col_q][tgt_row_q];
      case (fsm_q)
         INIT: begin
            // Display draws grid + cursor after reset: one high pulse on drawing.
            if (drawing) begin
               init_hi_d = 1'b1;
            end else if (init_hi_q) begin
               init_hi_d = 1'b0;
               fsm_d     = IDLE;
            end
         end
         IDLE: begin
            if ({tgt_col_q, tgt_row_q} != {disp_col_q, disp_row_q}) begin
               old_x_d    = pix_x(disp_col_q);
               old_y_d    = pix_y(disp_row_q);
               x_d        = pix_x(tgt_col_q);
               y_d        = pix_y(tgt_row_q);
               cell_d     = bitmap_q[disp_col_q][disp_row_q];
               disp_col_d = tgt_col_q;
               disp_row_d = tgt_row_q;
               fsm_d      = ISSUE;
            end
         end
         ISSUE:   fsm_d = W_START;
         W_START: if (drawing)  fsm_d = W_CUR;
         W_CUR:   if (!drawing) fsm_d = W_GAP;
         W_GAP:   if (drawing)  fsm_d = W_BOX;
         W_BOX:   if (!drawing) fsm_d = IDLE;
         default: fsm_d = INIT;
      endcase
   end

   // State and datapath registers; everything returns to the power-up cursor at (0,0).
   always_ff @(posedge CLOCK_50 or negedge nReset) begin
      if (!nReset) begin
         fsm_q      <= INIT;
         init_hi_q  <= 1'b0;
         tgt_col_q  <= 4'd0;
         tgt_row_q  <= 4'd0;
         disp_col_q <= 4'd0;
         disp_row_q <= 4'd0;
         bitmap_q   <= '0;
         x_q        <= 10'(X0);
         y_q        <= 9'(Y0);
         old_x_q    <= 10'(X0);
         old_y_q    <= 9'(Y0);
         cell_q     <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         init_hi_q  <= init_hi_d;
         tgt_col_q  <= tgt_col_d;
         tgt_row_q  <= tgt_row_d;
         disp_col_q <= disp_col_d;
         disp_row_q <= disp_row_d;
         bitmap_q   <= bitmap_d;
         x_q        <= x_d;
         y_q        <= y_d;
         old_x_q    <= old_x_d;
         old_y_q    <= old_y_d;
         cell_q     <= cell_d;
      end
   end

   // Outputs decode directly from registers; step column read is unregistered.
   always_comb begin
      draw_enable = (fsm_q == ISSUE);
      busy        = (fsm_q != IDLE);
      X           = x_q;
      Y           = y_q;
      OLD_X       = old_x_q;
      OLD_Y       = old_y_q;
      state       = cell_q;
      cursor_col  = tgt_col_q;
      cursor_row  = tgt_row_q;
      step_col    = '0;
      if (step_col_sel < 4'(GRID_N))
         step_col = bitmap_q[step_col_sel];
   end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with a simple vga_display handshake model.
// Checks reset, INIT, move latency, coalescing, toggle, edge behaviour and mid-transaction reset.
// Expected pixel values are hand computed: px = 214 + 33*col, py = 32 + 33*row.
module tb_draw_scheduler;

   logic        CLOCK_50 = 1'b0;
   logic        nReset = 1'b0;
   logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_toggle = 1'b0;
   logic        drawing;
   logic        drawing_init = 1'b0;
   logic        drawing_model = 1'b0;
   logic        draw_enable;
   logic [9:0]  X, OLD_X;
   logic [8:0]  Y, OLD_Y;
   logic        state;
   logic [3:0]  cursor_col, cursor_row;
   logic        busy;
   logic [3:0]  step_col_sel = 4'd0;
   logic [11:0] step_col;

   int total = 0;
   int bad = 0;
   int de_cnt = 0;
   int mdl_cnt = 0;

   assign drawing = drawing_init | drawing_model;

   draw_scheduler dut (
      .CLOCK_50(CLOCK_50), .nReset(nReset),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .btn_toggle(btn_toggle), .drawing(drawing), .draw_enable(draw_enable),
      .X(X), .Y(Y), .OLD_X(OLD_X), .OLD_Y(OLD_Y), .state(state),
      .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy),
      .step_col_sel(step_col_sel), .step_col(step_col)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // Display model: after draw_enable, cursor phase (10 high), 1-cycle gap, box phase (10 high).
   always @(negedge CLOCK_50) begin
      if (!nReset) begin
         mdl_cnt       = 0;
         drawing_model = 1'b0;
      end else if (mdl_cnt != 0) begin
         mdl_cnt       = mdl_cnt + 1;
         drawing_model = (mdl_cnt >= 2 && mdl_cnt <= 11) || (mdl_cnt >= 13 && mdl_cnt <= 22);
         if (mdl_cnt >= 23) mdl_cnt = 0;
      end else if (draw_enable) begin
         mdl_cnt = 1;
      end
      if (draw_enable) de_cnt = de_cnt + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      total = total + 1;
      if (got != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive a one-cycle button pulse {up,down,left,right,toggle}; returns one negedge later.
   task automatic press(input logic [4:0] b);
      {btn_up, btn_down, btn_left, btn_right, btn_toggle} = b;
      @(negedge CLOCK_50);
      {btn_up, btn_down, btn_left, btn_right, btn_toggle} = 5'b0;
   endtask

   task automatic wait_de(input string tag);
      for (int i = 0; i < 200; i++) begin
         if (draw_enable) break;
         @(negedge CLOCK_50);
      end
      check(tag, int'(draw_enable), 1);
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 200; i++) begin
         if (!busy && mdl_cnt == 0) break;
         @(negedge CLOCK_50);
      end
      check(tag, int'(busy), 0);
   endtask

   task automatic check_draw(input string tag, input int ox, input int oy,
                             input int nx, input int ny, input int st);
      check({tag, "_old_x"}, int'(OLD_X), ox);
      check({tag, "_old_y"}, int'(OLD_Y), oy);
      check({tag, "_x"}, int'(X), nx);
      check({tag, "_y"}, int'(Y), ny);
      check({tag, "_state"}, int'(state), st);
   endtask

   // Power-up display pulse on drawing; busy must stay high until it falls.
   task automatic init_phase(input string tag, input int len);
      int ever_idle;
      int de0;
      ever_idle = 0;
      de0 = de_cnt;
      drawing_init = 1'b1;
      repeat (len) begin
         @(negedge CLOCK_50);
         if (!busy) ever_idle = 1;
      end
      drawing_init = 1'b0;
      check({tag, "_busy_during"}, ever_idle, 0);
      check({tag, "_busy_at_fall"}, int'(busy), 1);
      @(negedge CLOCK_50);
      check({tag, "_busy_after"}, int'(busy), 0);
      check({tag, "_no_de"}, de_cnt - de0, 0);
   endtask

   initial begin
      int de0;
      repeat (2) @(negedge CLOCK_50);
      // Reset values
      check("rst_x", int'(X), 214);
      check("rst_y", int'(Y), 32);
      check("rst_old_x", int'(OLD_X), 214);
      check("rst_old_y", int'(OLD_Y), 32);
      check("rst_state", int'(state), 0);
      check("rst_de", int'(draw_enable), 0);
      check("rst_busy", int'(busy), 1);
      check("rst_col", int'(cursor_col), 0);
      check("rst_step_col", int'(step_col), 0);
      nReset = 1'b1;
      @(negedge CLOCK_50);
      init_phase("init", 100);

      // Right at cycle n: target at n+1, draw_enable only at n+2
      press(5'b00010);
      check("r1_col", int'(cursor_col), 1);
      check("r1_de_n1", int'(draw_enable), 0);
      @(negedge CLOCK_50);
      check("r1_de_n2", int'(draw_enable), 1);
      check_draw("r1", 214, 32, 247, 32, 0);
      @(negedge CLOCK_50);
      check("r1_de_n3", int'(draw_enable), 0);
      // Three rights during the cursor phase coalesce into one follow-up
      @(negedge CLOCK_50);
      press(5'b00010); @(negedge CLOCK_50);
      press(5'b00010); @(negedge CLOCK_50);
      press(5'b00010);
      check("coal_col", int'(cursor_col), 4);
      check("coal_inflight", int'(busy), 1);
      wait_de("coal_de");
      check_draw("coal", 247, 32, 346, 32, 0);
      wait_idle("coal_idle");
      repeat (10) @(negedge CLOCK_50);
      check("coal_de_total", de_cnt, 2);

      // Opposing pulses cancel
      de0 = de_cnt;
      press(5'b00110);
      check("cancel_col", int'(cursor_col), 4);
      repeat (10) @(negedge CLOCK_50);
      check("cancel_no_de", de_cnt - de0, 0);
      check("cancel_busy", int'(busy), 0);

      // Four lefts: first issues 4->3, remaining three coalesce into 3->0
      de0 = de_cnt;
      press(5'b00100); @(negedge CLOCK_50);
      press(5'b00100); @(negedge CLOCK_50);
      press(5'b00100); @(negedge CLOCK_50);
      press(5'b00100);
      check("l4_col", int'(cursor_col), 0);
      check_draw("l4a", 346, 32, 313, 32, 0);
      @(negedge CLOCK_50);
      wait_idle("l4_mid");
      wait_de("l4b_de");
      check_draw("l4b", 313, 32, 214, 32, 0);
      wait_idle("l4_idle");
      repeat (5) @(negedge CLOCK_50);
      check("l4_de_total", de_cnt - de0, 2);

      // Toggle at (0,0): visible next cycle, no draw
      de0 = de_cnt;
      step_col_sel = 4'd0;
      @(negedge CLOCK_50);
      check("tog_before", int'(step_col), 12'h000);
      press(5'b00001);
      check("tog_after", int'(step_col), 12'h001);
      repeat (5) @(negedge CLOCK_50);
      check("tog_no_de", de_cnt - de0, 0);
      // Down: vacated cell is now set
      press(5'b01000);
      @(negedge CLOCK_50);
      check("dn_de", int'(draw_enable), 1);
      check_draw("dn", 214, 32, 214, 65, 1);
      wait_idle("dn_idle");

      // Toggle with right: pre-move cell (0,1) flips
      press(5'b00011);
      check("tr_step", int'(step_col), 12'h003);
      check("tr_col", int'(cursor_col), 1);
      check("tr_row", int'(cursor_row), 1);
      wait_de("tr_de");
      check_draw("tr", 214, 65, 247, 65, 1);
      wait_idle("tr_idle");

      // Back to col 0, then left at the edge
      press(5'b00100);
      wait_de("l0_de");
      check_draw("l0", 247, 65, 214, 65, 0);
      wait_idle("l0_idle");
      de0 = de_cnt;
      press(5'b00100);
`ifdef DRAW_SCHED_WRAP_EN
      check("edge_col", int'(cursor_col), 11);
      wait_de("edge_de");
      check_draw("edge", 214, 65, 577, 65, 1);
      wait_idle("edge_idle");
`else
      check("edge_col", int'(cursor_col), 0);
      repeat (10) @(negedge CLOCK_50);
      check("edge_no_de", de_cnt - de0, 0);
      check("edge_busy", int'(busy), 0);
`endif

      // Reset asserted during the box phase
      press(5'b01000);
      for (int i = 0; i < 200; i++) begin
         if (mdl_cnt >= 15) break;
         @(negedge CLOCK_50);
      end
      check("mr_in_box", int'(mdl_cnt >= 15 && mdl_cnt <= 20), 1);
      nReset = 1'b0;
      #1;
      check("mr_x", int'(X), 214);
      check("mr_y", int'(Y), 32);
      check("mr_old_x", int'(OLD_X), 214);
      check("mr_state", int'(state), 0);
      check("mr_busy", int'(busy), 1);
      check("mr_col", int'(cursor_col), 0);
      check("mr_row", int'(cursor_row), 0);
      check("mr_step_col", int'(step_col), 0);
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      check("mr_de", int'(draw_enable), 0);
      nReset = 1'b1;
      @(negedge CLOCK_50);
      init_phase("reinit", 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Sequencing controller in front of `vga_display`. It owns the 12x12 step bitmap and the cursor position, and accepts single-cycle button pulses from the input decoder. It schedules one cursor-move transaction at a time on the display's `draw_enable`/`drawing` handshake, merging moves that arrive while a draw is in flight. It also gives the playback sequencer a column read port into the bitmap.

## Interface
- GRID_N, 12, cells per row/column
- X0, 214, pixel x of cell (0,0)
- Y0, 32, pixel y of cell (0,0)
- PITCH, 33, cell pitch in pixels
- CLOCK_50  in  1  system clock
- nReset  in  1  asynchronous, active-low reset
- btn_up, btn_down, btn_left, btn_right  in  1 each  single-cycle move pulses
- btn_toggle  in  1  single-cycle pulse; toggles the step at the cursor
- drawing  in  1  busy flag from the display
- draw_enable  out  1  single-cycle transaction start
- X  out  10;  Y  out  9  new cursor pixel origin
- OLD_X  out  10;  OLD_Y  out  9  pixel origin of the cell being vacated
- state  out  1  bitmap value of the vacated cell
- cursor_col, cursor_row  out  4 each  target cursor
- busy  out  1  high in every state except IDLE
- step_col_sel  in  4;  step_col  out  12  combinational read; bit r = bitmap[step_col_sel][r]

## Operation
- Registers:
  - target (col,row): updated immediately by button pulses
  - disp (col,row): last cursor cell drawn
  - 144-bit bitmap
- Moves:
  - up: row-1; down: row+1; left: col-1; right: col+1
  - Opposing pulses in the same cycle cancel.
  - One horizontal and one vertical pulse in the same cycle both apply.
- Toggle:
  - Flips bitmap[target] using the pre-move target when it coincides with a move.
  - Never starts a draw, because the cursor covers the cell.
- Pixel math is registered:
  - px = X0 + PITCH*col (10 bit)
  - py = Y0 + PITCH*row (9 bit)
  - Maximum values are 577 and 395; no overflow.
- FSM states:
  - INIT: wait for `drawing` to rise, then fall (display power-up grid + cursor) → IDLE.
  - IDLE: if target≠disp, latch OLD←px/py(disp), X/Y←px/py(target), state←bitmap[disp], disp←target → ISSUE.
  - ISSUE: draw_enable=1 for one cycle → W_START.
  - W_START: wait for drawing=1 → W_CUR.
  - W_CUR: wait for drawing=0 → W_GAP.
  - W_GAP: wait for drawing=1 → W_BOX.
  - W_BOX: wait for drawing=0 → IDLE.
- A transaction spans two falling edges of `drawing`: the cursor phase and the box phase, separated by a one-cycle low gap.
- Coalescing rule: any number of moves during a transaction collapse to one follow-up draw from the new disp to the final target. Last value wins.
- If the target returns to disp before IDLE, no draw is issued.

## Timing
- Reset values:
  - X=OLD_X=214, Y=OLD_Y=32
  - state=0, draw_enable=0, busy=1 (INIT)
  - cursor 0,0; disp 0,0; bitmap all 0
- Move pulse at cycle n while in IDLE: target updates at n+1; draw_enable is high during cycle n+2.
- X, Y, OLD_X, OLD_Y and state are stable from ISSUE until the return to IDLE. The display samples `state` throughout its box phase.
- step_col has zero-cycle latency; a toggle is visible the cycle after the pulse.
- Reset mid-transaction: all registers return to reset values and the FSM restarts in INIT. The display shares nReset and redraws the grid plus the cursor at (214,32).

## Configuration
- DRAW_SCHED_WRAP_EN defined: moves wrap around (col 11 + right → 0; row 0 + up → 11).
- Undefined: moves saturate at 0 and GRID_N-1; a saturated pulse changes nothing and starts no draw.

## Test plan
- Reset, display model pulses drawing for 100 cycles → busy stays 1 until drawing falls, then 0; no draw_enable during INIT.
- IDLE, btn_right at cycle n → draw_enable high at n+2 only; X=247, Y=32, OLD_X=214, OLD_Y=32, state=0.
- btn_toggle at (0,0), then btn_down → state=1, OLD=(214,32), X/Y=(214,65); step_col_sel=0 gives step_col=12'h001.
- Three btn_right pulses during the W_CUR phase of a transaction → exactly one follow-up draw_enable after W_BOX; OLD=(247,32), X=(346,32).
- btn_left and btn_right in the same cycle → target unchanged, no draw_enable. At col 0, btn_left → col 11, X=577 (WRAP_EN); without WRAP_EN → col stays 0, no draw_enable.
- nReset asserted during W_BOX → all outputs at reset values next edge; FSM back in INIT.
